seven_seg_field_driver: RTL and testbench

Sequential, parametrised successor to the stopwatch's combinational binary-to-seven-segment path. Captures NUM_FIELDS packed binary fields on a request. Converts each field in turn with a shared iterative double-dabble engine. Drives DIGITS_PER_FIELD seven-segment bytes per field, with leading-zero blanking, per-digit decimal points, overflow dashes, one-deep request buffering and atomic display update. Sits between the stopwatch counter and the board HEX displays.

---
 rtl/seven_seg_field_driver.sv | 231 +++++++++++++++++++++++
 tb/tb_seven_seg_field_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_field_driver.sv
// seven_seg_field_driver
//   Captures NUM_FIELDS packed binary fields on a request, converts them one
//   after another with a single shared iterative double-dabble engine, and
//   drives DIGITS_PER_FIELD seven-segment bytes per field. Supports
//   leading-zero blanking, per-digit decimal points, overflow dashes, a
//   one-deep request buffer, and an atomic display update (hex never shows
//   a partially converted result).
//
// Ports
//   clock     rising-edge system clock
//   reset_n   asynchronous active-low reset
//   update    single-cycle request to sample and convert the fields
//   fields    packed binary values; field f at [f*FIELD_WIDTH +: FIELD_WIDTH]
//   dp_mask   1 = light the dp of digit (f*D+d)
//   blank_lz  1 = leading-zero blanking for field f
//   hex       byte (f*D+d) at [(f*D+d)*8 +: 8]; bit0..6 = a..g, bit7 = dp
//   busy      conversion in progress
//   done      one-cycle pulse when hex has been updated

// Per-digit encoder. Output is always in active-low form.
module seven_seg_digit_enc (
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    input  logic       dp,
    output logic [7:0] seg_al
);
    logic [7:0] seg;

    always_comb begin
        seg = 8'hFF;
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        // Dash overrides everything; blanking overrides the digit glyph.
        if (dash)
            seg = 8'hBF;
        else if (blank)
            seg = 8'hFF;
        // dp goes on top of whatever glyph (including blank) was chosen.
        seg_al = {~dp, seg[6:0]};
    end
endmodule

module seven_seg_field_driver #(
    parameter int NUM_FIELDS       = 3,
    parameter int FIELD_WIDTH      = 7,
    parameter int DIGITS_PER_FIELD = 2,
    parameter int ACTIVE_LOW       = 1
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic                                   update,
    input  logic [NUM_FIELDS*FIELD_WIDTH-1:0]      fields,
    input  logic [NUM_FIELDS*DIGITS_PER_FIELD-1:0] dp_mask,
    input  logic [NUM_FIELDS-1:0]                  blank_lz,
    output logic [NUM_FIELDS*DIGITS_PER_FIELD*8-1:0] hex,
    output logic                                   busy,
    output logic                                   done
);
    localparam int NB = NUM_FIELDS * DIGITS_PER_FIELD;
    // One extra BCD digit beyond the displayed ones to detect overflow.
    localparam int BW = 4 * (DIGITS_PER_FIELD + 1);
    localparam int IW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int CW = $clog2(FIELD_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

    typedef struct packed {
        logic [NUM_FIELDS*FIELD_WIDTH-1:0] fields;
        logic [NB-1:0]                     dp_mask;
        logic [NUM_FIELDS-1:0]             blank_lz;
    } req_t;

    state_t                        state, state_nxt;
    req_t                          shadow;
    logic                          pending;
    logic [IW-1:0]                 idx;
    logic [CW-1:0]                 count;
    logic [FIELD_WIDTH-1:0]        bin;
    logic [BW-1:0]                 bcd;
    logic [NB-1:0][7:0]            staging, staging_nxt, hex_al;
    logic                          done_r;

    logic                          last_field;
    logic [FIELD_WIDTH-1:0]        cur_field;
    logic [DIGITS_PER_FIELD-1:0]   cur_dp;
    logic                          cur_blz;
    logic [BW-1:0]                 bcd_adj, bcd_sh;
    logic [FIELD_WIDTH-1:0]        bin_sh;
    logic                          overflow;
    logic [DIGITS_PER_FIELD-1:0]   blank;
    logic                          lz_run;
    logic [DIGITS_PER_FIELD-1:0][7:0] enc;

    assign last_field = (idx == IW'(NUM_FIELDS - 1));
    assign busy       = (state != IDLE);
    assign done       = done_r;
    assign hex        = (ACTIVE_LOW != 0) ? hex_al : ~hex_al;

    // Select the shadowed inputs belonging to the field being converted.
    always_comb begin
        cur_field = '0;
        cur_dp    = '0;
        cur_blz   = 1'b0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (IW'(f) == idx) begin
                cur_field = shadow.fields[f*FIELD_WIDTH +: FIELD_WIDTH];
                cur_dp    = shadow.dp_mask[f*DIGITS_PER_FIELD +: DIGITS_PER_FIELD];
                cur_blz   = shadow.blank_lz[f];
            end
        end
    end

    // Double-dabble step: add-3 correction, then shift {bcd,bin} left.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k <= DIGITS_PER_FIELD; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
        bcd_sh = {bcd_adj[BW-2:0], bin[FIELD_WIDTH-1]};
        bin_sh = {bin[FIELD_WIDTH-2:0], 1'b0};
    end

    assign overflow = (bcd[BW-1 -: 4] != 4'd0);

    // Leading-zero blanking walks from the most significant digit down and
    // stops at the first non-zero digit; digit 0 always shows.
    always_comb begin
        blank  = '0;
        lz_run = cur_blz;
        for (int d = DIGITS_PER_FIELD - 1; d >= 0; d--) begin
            if (lz_run && (d != 0) && (bcd[4*d +: 4] == 4'd0))
                blank[d] = 1'b1;
            else
                lz_run = 1'b0;
        end
    end

    for (genvar d = 0; d < DIGITS_PER_FIELD; d++) begin : g_dig
        seven_seg_digit_enc u_enc (
            .digit  (bcd[4*d +: 4]),
            .blank  (blank[d]),
            .dash   (overflow),
            .dp     (cur_dp[d]),
            .seg_al (enc[d])
        );
    end

    // Staging image with the current field's bytes replaced; on the last
    // field this whole image is committed to hex in one edge.
    always_comb begin
        staging_nxt = staging;
        for (int b = 0; b < NB; b++) begin
            if (IW'(b / DIGITS_PER_FIELD) == idx)
                staging_nxt[b] = enc[b % DIGITS_PER_FIELD];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (update || pending) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (count == CW'(1)) state_nxt = STORE;
            STORE:   state_nxt = last_field ? IDLE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shadow  <= '0;
            pending <= 1'b0;
            idx     <= '0;
            count   <= '0;
            bin     <= '0;
            bcd     <= '0;
            staging <= '1;
            hex_al  <= '1;
            done_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= 1'b0;
            // Requests arriving while busy collapse into one pending flag.
            if (update && (state != IDLE))
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (update || pending) begin
                        shadow  <= '{fields: fields, dp_mask: dp_mask, blank_lz: blank_lz};
                        pending <= 1'b0;
                        idx     <= '0;
                    end
                end
                LOAD: begin
                    bin   <= cur_field;
                    bcd   <= '0;
                    count <= CW'(FIELD_WIDTH);
                end
                SHIFT: begin
                    bin   <= bin_sh;
                    bcd   <= bcd_sh;
                    count <= count - 1'b1;
                end
                STORE: begin
                    staging <= staging_nxt;
                    if (last_field) begin
                        hex_al <= staging_nxt;
                        done_r <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seven_seg_field_driver.sv
module tb_seven_seg_field_driver;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        update = 1'b0;
    logic [20:0] fields = '0;
    logic [5:0]  dp_mask = '0;
    logic [2:0]  blank_lz = '0;
    logic [47:0] hex, hex_n;
    logic        busy, done, busy_n, done_n;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    seven_seg_field_driver #(.ACTIVE_LOW(1)) dut (
        .clock(clock), .reset_n(reset_n), .update(update), .fields(fields),
        .dp_mask(dp_mask), .blank_lz(blank_lz), .hex(hex), .busy(busy), .done(done)
    );

    seven_seg_field_driver #(.ACTIVE_LOW(0)) dut_n (
        .clock(clock), .reset_n(reset_n), .update(update), .fields(fields),
        .dp_mask(dp_mask), .blank_lz(blank_lz), .hex(hex_n), .busy(busy_n), .done(done_n)
    );

    task automatic set_fields(input int f2, input int f1, input int f0);
        fields = {7'(f2), 7'(f1), 7'(f0)};
    endtask

    // Request pulse centred on one rising edge (the capture edge).
    task automatic pulse_update();
        @(negedge clock);
        update = 1'b1;
        @(negedge clock);
        update = 1'b0;
    endtask

    // Returns the number of edges after the capture edge until done, or -1.
    task automatic wait_done(output int n, output bit busy_ok);
        n = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            #1;
            if (done) begin
                n = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        tests++; if (hex !== 48'hFFFF_FFFF_FFFF) begin fails++; $display("FAIL reset_hex: got %h expected %h", hex, 48'hFFFF_FFFF_FFFF); end
        tests++; if (hex_n !== 48'h0) begin fails++; $display("FAIL reset_hex_n: got %h expected %h", hex_n, 48'h0); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int  n;
        bit  bok;
        set_fields(5, 42, 7);
        dp_mask = '0;
        blank_lz = '0;
        pulse_update();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_start: got %b expected 1", busy); end
        wait_done(n, bok);
        tests++; if (n != 27) begin fails++; $display("FAIL basic_latency: got %0d expected 27", n); end
        tests++; if (!bok) begin fails++; $display("FAIL basic_busy_hold: got busy drop expected busy held"); end
        tests++; if (hex !== 48'hC0_92_99_A4_C0_F8) begin fails++; $display("FAIL basic_hex: got %h expected %h", hex, 48'hC0_92_99_A4_C0_F8); end
        @(posedge clock);
        #1;
        tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_blanking();
        int n;
        bit bok;
        set_fields(0, 42, 7);
        blank_lz = 3'b101;
        pulse_update();
        wait_done(n, bok);
        tests++; if (hex !== 48'hFF_C0_99_A4_FF_F8) begin fails++; $display("FAIL blank_hex: got %h expected %h", hex, 48'hFF_C0_99_A4_FF_F8); end
        blank_lz = '0;
    endtask

    task automatic test_overflow();
        int n;
        bit bok;
        set_fields(10, 99, 127);
        pulse_update();
        wait_done(n, bok);
        tests++; if (hex !== 48'hF9_C0_90_90_BF_BF) begin fails++; $display("FAIL overflow_hex: got %h expected %h", hex, 48'hF9_C0_90_90_BF_BF); end
    endtask

    task automatic test_dp();
        int n;
        bit bok;
        set_fields(5, 42, 7);
        dp_mask = 6'b000100;
        pulse_update();
        wait_done(n, bok);
        tests++; if (hex !== 48'hC0_92_99_24_C0_F8) begin fails++; $display("FAIL dp_hex: got %h expected %h", hex, 48'hC0_92_99_24_C0_F8); end
        tests++; if (hex_n !== 48'h3F_6D_66_DB_3F_07) begin fails++; $display("FAIL dp_hex_inv: got %h expected %h", hex_n, 48'h3F_6D_66_DB_3F_07); end
        tests++; if (done_n !== 1'b1) begin fails++; $display("FAIL dp_done_inv: got %b expected 1", done_n); end
        dp_mask = '0;
    endtask

    task automatic test_back_to_back();
        int          ndone = 0;
        int          t1 = -1;
        int          t2 = -1;
        logic [47:0] h1 = '0;
        logic [47:0] h2 = '0;
        set_fields(5, 42, 7);
        pulse_update();
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin t1 = i; h1 = hex; end
                if (ndone == 2) begin t2 = i; h2 = hex; end
            end
            update = (i == 3) || (i == 10) || (i == 20);
            if (i == 3) set_fields(12, 34, 56);
        end
        update = 1'b0;
        tests++; if (ndone != 2) begin fails++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
        tests++; if (t1 != 27) begin fails++; $display("FAIL b2b_first_latency: got %0d expected 27", t1); end
        tests++; if (t2 - t1 != 28) begin fails++; $display("FAIL b2b_gap: got %0d expected 28", t2 - t1); end
        tests++; if (h1 !== 48'hC0_92_99_A4_C0_F8) begin fails++; $display("FAIL b2b_first_hex: got %h expected %h", h1, 48'hC0_92_99_A4_C0_F8); end
        tests++; if (h2 !== 48'hF9_A4_B0_99_92_82) begin fails++; $display("FAIL b2b_second_hex: got %h expected %h", h2, 48'hF9_A4_B0_99_92_82); end
    endtask

    task automatic test_reset_midway();
        int n;
        bit bok;
        bit saw_done = 1'b0;
        set_fields(5, 42, 7);
        pulse_update();
        // Edge 13 after capture lands in SHIFT of field 1.
        repeat (13) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        tests++; if (hex !== 48'hFFFF_FFFF_FFFF) begin fails++; $display("FAIL midrst_hex: got %h expected %h", hex, 48'hFFFF_FFFF_FFFF); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) saw_done = 1'b1;
        end
        tests++; if (saw_done) begin fails++; $display("FAIL midrst_no_done: got done pulse expected none"); end
        set_fields(9, 60, 3);
        pulse_update();
        wait_done(n, bok);
        tests++; if (n != 27) begin fails++; $display("FAIL midrst_latency: got %0d expected 27", n); end
        tests++; if (hex !== 48'hC0_90_82_C0_C0_B0) begin fails++; $display("FAIL midrst_hex_after: got %h expected %h", hex, 48'hC0_90_82_C0_C0_B0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blanking();
        test_overflow();
        test_dp();
        test_back_to_back();
        test_reset_midway();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
